// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch stage. Owns the PC, fetches from instruction memory
//   over a req/ready handshake (data returned in the accepting cycle), and
//   feeds the IF->ID register. A one-entry hold buffer absorbs ID stalls;
//   redirects squash the wrong path. A redirect that arrives while a request
//   is outstanding is parked in a pending-target register until memory
//   completes the old request.
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous active-high reset
//   imem_req     out  1   instruction memory request
//   imem_addr    out  32  fetch address (current PC)
//   imem_ready   in   1   memory accepts request, data valid this cycle
//   imem_rdata   in   32  instruction word
//   stall        in   1   hold the IF->ID register
//   redirect     in   1   branch/jump taken
//   redirect_pc  in   32  redirect target
//   pc4_if       out  32  PC+4 of presented instruction, 0 for a bubble
//   instr_if     out  32  presented instruction or NOP_INSTR
//   ifid_enable  out  1   IF->ID register write enable
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc4_if,
  output logic [31:0] instr_if,
  output logic        ifid_enable
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] buffer, buffer_nxt;
  logic [31:0] buf_pc4, buf_pc4_nxt;
  logic [31:0] pending, pending_nxt;
  logic [31:0] pc_plus4;

  // Sequential PC increment; wraps modulo 2^32.
  function automatic logic [31:0] inc4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  assign pc_plus4  = inc4(pc);
  assign imem_addr = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      buffer  <= '0;
      buf_pc4 <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      buffer  <= buffer_nxt;
      buf_pc4 <= buf_pc4_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    buffer_nxt  = buffer;
    buf_pc4_nxt = buf_pc4;
    pending_nxt = pending;
    imem_req    = 1'b0;
    pc4_if      = '0;
    instr_if    = NOP_INSTR;
    ifid_enable = ~stall;

    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect) begin
          ifid_enable = 1'b1;
          pc_nxt      = redirect_pc;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_enable = 1'b1;
          if (imem_ready) begin
            pc_nxt = redirect_pc;
          end else begin
            // Old request must still complete at its address.
            pending_nxt = redirect_pc;
            state_nxt   = DROP;
          end
        end else if (imem_ready) begin
          pc_nxt = pc_plus4;
          if (!stall) begin
            instr_if    = imem_rdata;
            pc4_if      = pc_plus4;
            ifid_enable = 1'b1;
          end else begin
            ifid_enable = 1'b0;
            buffer_nxt  = imem_rdata;
            buf_pc4_nxt = pc_plus4;
            state_nxt   = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          ifid_enable = 1'b1;
          pc_nxt      = redirect_pc;
          state_nxt   = REQ;
        end else begin
          instr_if = buffer;
          pc4_if   = buf_pc4;
          if (!stall) state_nxt = REQ;
        end
      end

      DROP: begin
        imem_req = 1'b1;
        if (redirect) begin
          ifid_enable = 1'b1;
          pending_nxt = redirect_pc;
        end
        if (imem_ready) begin
          // Wrong-path data is discarded; newest target wins.
          pc_nxt    = redirect ? redirect_pc : pending;
          state_nxt = REQ;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Reset values are visible immediately, not at the next edge.
    if (reset) begin
      imem_req    = 1'b0;
      pc4_if      = '0;
      instr_if    = NOP_INSTR;
      ifid_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, stall, redirect, ifid_enable;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc4_if, instr_if;
  logic        imem_req_w, ifid_enable_w;
  logic [31:0] imem_addr_w, imem_rdata_w, pc4_if_w, instr_if_w;

  always #5 clock = ~clock;

  // Memory returns addr|1 as the instruction word.
  assign imem_rdata   = imem_addr | 32'h1;
  assign imem_rdata_w = imem_addr_w | 32'h1;

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc4_if(pc4_if),
    .instr_if(instr_if), .ifid_enable(ifid_enable));

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_w (
    .clock(clock), .reset(reset), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata_w), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc4_if(pc4_if_w),
    .instr_if(instr_if_w), .ifid_enable(ifid_enable_w));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rdy;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] pc4, input logic [31:0] ins, input logic en,
                         input logic chk_data);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".en"}, {31'b0, ifid_enable}, {31'b0, en});
    if (chk_data) begin
      chk({tag, ".pc4"}, pc4_if, pc4);
      chk({tag, ".instr"}, instr_if, ins);
    end
  endtask

  typedef struct {
    logic        s, r, rdy;
    logic [31:0] rp;
    logic        req;
    logic [31:0] addr, pc4, ins;
    logic        en, cd;
  } vec_t;

  vec_t vecs[15];

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] ins, pc4; } ent_t;
  bit          m_started, m_drop;
  logic [31:0] m_pc, m_tgt;
  ent_t        m_hold[$];

  task automatic model_reset();
    m_started = 0; m_drop = 0; m_pc = 32'h0; m_tgt = 32'h0; m_hold.delete();
  endtask

  task automatic model_eval(output logic req, output logic [31:0] addr, output logic [31:0] pc4,
                            output logic [31:0] ins, output logic en, output logic cd);
    req = m_started && (m_hold.size() == 0);
    addr = m_pc; pc4 = 0; ins = 0; en = !stall; cd = 1;
    if (redirect) en = 1;
    else if (!m_started || m_drop) en = !stall;
    else if (m_hold.size() != 0) begin ins = m_hold[0].ins; pc4 = m_hold[0].pc4; end
    else if (imem_ready) begin
      if (!stall) begin ins = m_pc | 32'h1; pc4 = m_pc + 32'd4; en = 1; end
      else begin en = 0; cd = 0; end
    end
  endtask

  task automatic model_update();
    if (!m_started) begin
      m_started = 1;
      if (redirect) m_pc = redirect_pc;
    end else if (m_hold.size() != 0) begin
      if (redirect) begin m_hold.delete(); m_pc = redirect_pc; end
      else if (!stall) m_hold.delete();
    end else if (m_drop) begin
      if (redirect) m_tgt = redirect_pc;
      if (imem_ready) begin m_pc = m_tgt; m_drop = 0; end
    end else if (redirect) begin
      if (imem_ready) m_pc = redirect_pc;
      else begin m_drop = 1; m_tgt = redirect_pc; end
    end else if (imem_ready) begin
      if (stall) m_hold.push_back('{ins: m_pc | 32'h1, pc4: m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    logic        e_req, e_en, e_cd;
    logic [31:0] e_addr, e_pc4, e_ins;

    //               s  r  rdy rp           req addr          pc4           ins           en cd
    vecs[0]  = '{1'b0,1'b0,1'b1,32'h0,   1'b0,32'h0,  32'h0,  32'h0,  1'b1,1'b1};
    vecs[1]  = '{1'b0,1'b0,1'b1,32'h0,   1'b1,32'h0,  32'h4,  32'h1,  1'b1,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,32'h0,   1'b1,32'h4,  32'h8,  32'h5,  1'b1,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b1,32'h0,   1'b1,32'h8,  32'hC,  32'h9,  1'b1,1'b1};
    vecs[4]  = '{1'b0,1'b0,1'b1,32'h0,   1'b1,32'hC,  32'h10, 32'hD,  1'b1,1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b1,32'h0,   1'b1,32'h10, 32'h0,  32'h0,  1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b1,32'h0,   1'b0,32'h14, 32'h14, 32'h11, 1'b0,1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b1,32'h0,   1'b0,32'h14, 32'h14, 32'h11, 1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b1,32'h0,   1'b0,32'h14, 32'h14, 32'h11, 1'b1,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b1,32'h0,   1'b1,32'h14, 32'h18, 32'h15, 1'b1,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b1,32'h0,   1'b1,32'h18, 32'h0,  32'h0,  1'b0,1'b0};
    vecs[11] = '{1'b1,1'b1,1'b1,32'h100, 1'b0,32'h1C, 32'h0,  32'h0,  1'b1,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,32'h0,   1'b1,32'h100,32'h0,  32'h0,  1'b1,1'b1};
    vecs[13] = '{1'b0,1'b0,1'b1,32'h0,   1'b1,32'h100,32'h104,32'h101,1'b1,1'b1};
    vecs[14] = '{1'b1,1'b0,1'b0,32'h0,   1'b1,32'h104,32'h0,  32'h0,  1'b0,1'b1};

    drive(0, 0, 0, 1);
    reset = 1'b1;
    @(negedge clock); @(negedge clock); #1;
    chk_all("rst", 0, 32'h0, 32'h0, 32'h0, 0, 1);
    chk("rst_w.addr", imem_addr_w, 32'hFFFF_FFFC);
    chk("rst_w.instr", instr_if_w, 32'h13);
    reset = 1'b0;

    // Table-driven sequence: reset release, back-to-back, stall/hold, redirect in HOLD
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].s, vecs[i].r, vecs[i].rp, vecs[i].rdy);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].pc4,
              vecs[i].ins, vecs[i].en, vecs[i].cd);
      if (i == 0) chk("wrap.idle_instr", instr_if_w, 32'h13);
      if (i == 1) begin
        chk("wrap.pc4", pc4_if_w, 32'h0);
        chk("wrap.instr", instr_if_w, 32'hFFFF_FFFD);
      end
      if (i == 2) chk("wrap.next_addr", imem_addr_w, 32'h0);
      @(negedge clock);
    end

    // Redirect with ready=1 to reach pc=0x40 (state REQ, pc=0x104 before)
    drive(0, 1, 32'h40, 1); #1;
    chk_all("rd40", 1, 32'h104, 0, 0, 1, 1);
    @(negedge clock);
    // Redirect to 0x200 while request at 0x40 is not ready
    drive(0, 1, 32'h200, 0); #1;
    chk_all("drop.enter", 1, 32'h40, 0, 0, 1, 1);
    @(negedge clock);
    drive(0, 0, 0, 0); #1;
    chk_all("drop.wait1", 1, 32'h40, 0, 0, 1, 1);
    @(negedge clock);
    drive(1, 0, 0, 0); #1;
    chk_all("drop.wait2", 1, 32'h40, 0, 0, 0, 1);
    @(negedge clock);
    drive(0, 0, 0, 1); #1;
    chk_all("drop.done", 1, 32'h40, 0, 0, 1, 1);
    @(negedge clock);
    drive(0, 0, 0, 0); #1;
    chk_all("drop.target", 1, 32'h200, 0, 0, 1, 1);
    @(negedge clock);
    // Second redirect during DROP wins
    drive(0, 1, 32'h280, 0); #1;
    chk_all("drop2.enter", 1, 32'h200, 0, 0, 1, 1);
    @(negedge clock);
    drive(1, 1, 32'h300, 0); #1;
    chk_all("drop2.redir", 1, 32'h200, 0, 0, 1, 1);
    @(negedge clock);
    drive(0, 0, 0, 1); #1;
    chk_all("drop2.done", 1, 32'h200, 0, 0, 1, 1);
    @(negedge clock);
    drive(0, 0, 0, 1); #1;
    chk_all("drop2.target", 1, 32'h300, 32'h304, 32'h301, 1, 1);
    @(negedge clock);

    // Enter DROP, then assert reset mid-cycle
    drive(0, 1, 32'h500, 0); #1;
    @(negedge clock);
    drive(0, 1, 32'h600, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 32'h0, 0, 0, 0, 1);
    @(negedge clock);
    drive(0, 0, 0, 1);
    reset = 1'b0; #1;
    chk_all("post_rst.idle", 0, 32'h0, 0, 0, 1, 1);
    @(negedge clock); #1;
    chk_all("post_rst.fetch", 1, 32'h0, 32'h4, 32'h1, 1, 1);
    @(negedge clock);

    // Randomized stimulus against the reference model
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom % 10) < 3, ($urandom % 10) == 0, $urandom & 32'h0000_FFFC,
            ($urandom % 10) < 6);
      #1;
      model_eval(e_req, e_addr, e_pc4, e_ins, e_en, e_cd);
      chk_all($sformatf("rnd%0d", n), e_req, e_addr, e_pc4, e_ins, e_en, e_cd);
      model_update();
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
